mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage of the 5-stage MIPS core, between EX and WB. Registers ex_to_mem_bus and
//  extracts/extends load data from the data SRAM. Waits for a variable-latency load response.
//  Forwards its result to ID for bypassing. Produces the 174-bit mem_to_wb_bus that WB registers.
// PARAMETERS
//  LOAD_WAIT_EN  1  1: honour data_sram_rvalid; 0: rvalid treated as 1 (rdata valid cycle after req)
// PORTS
//  clk               in   1    clock
//  rst               in   1    reset, synchronous, active-high
//  flush             in   1    exception flush from CP0
//  stall             in   6    `StallBus; bit3 = MEM, bit4 = WB, `Stop=1
//  ex_to_mem_bus     in   179  `EX_TO_MEM_WD (layout below)
//  data_sram_rdata   in   32   load word from data SRAM
//  data_sram_rvalid  in   1    rdata valid this cycle
//  mem_to_wb_bus     out  174  `MEM_TO_WB_WD, same field layout WB decodes
//  mem_to_id_bus     out  104  {lo_we,lo_wdata,hi_we,hi_wdata,rf_we,rf_waddr,rf_wdata} bypass
//  stallreq_for_mem  out  1    load data outstanding; to stall controller
// BEHAVIOUR
//  ex_to_mem_bus fields: badvaddr[178:147] delayslot[146] excepttype[145:141] lo_we[140]
//   lo_wdata[139:108] hi_we[107] hi_wdata[106:75] mem_op[74:72] addr_lo[71:70] pc[69:38]
//   rf_we[37] rf_waddr[36:32] ex_result[31:0].
//  mem_op: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, others = none.
//  Input reg priority: rst > flush > (stall[3]=Stop & stall[4]=NoStop: load 0 = bubble)
//   > (stall[3]=NoStop: load bus) > hold. All-zero bus = bubble: no writes, mem_op none.
//  Load extract: LB/LBU use byte addr_lo; LH/LHU use half addr_lo[1]. LB/LH sign-extend,
//   LBU/LHU zero-extend. LW uses the word. Misaligned addresses were already flagged by EX.
//  rf_wdata = extracted load data when mem_op is a load, else ex_result.
//  Exception: excepttype!=0 forces rf_we, hi_we and lo_we to 0 on both output buses.
//   No load wait is started. pc, excepttype, badvaddr and delayslot still pass to WB.
//  Load FSM, 2-bit state:
//   IDLE: registered load (no exception) & rvalid -> use rdata now, stay IDLE.
//         registered load (no exception) & !rvalid -> WAIT.
//   WAIT: stallreq_for_mem=1 (combinational in WAIT and in IDLE-with-load-no-rvalid).
//         rvalid & stall[3]=NoStop next -> IDLE. rvalid & stall still Stop -> capture into
//         data_buf, go HOLD.
//   HOLD: output uses data_buf, stallreq=0, rvalid ignored. -> IDLE when stall[3]=NoStop.
//  IDLE also captures data_buf if rvalid arrives while stall[3]=Stop, then goes HOLD.
//  Result: one-shot rvalid is never lost while a later stage stalls.
//  flush in any state -> IDLE, data_buf cleared, stallreq=0 next cycle.
//   Late rvalid after flush is ignored.
//  Reset: input reg 0, state IDLE, data_buf 0. All outputs 0, including stallreq.
//  Latency: one register (EX->MEM), combinational to WB. Load adds 0 cycles if rvalid same cycle.
//  mem_to_id_bus carries the same values as the WB-bound fields. rf_we there is 0 while
//   stallreq_for_mem=1, so ID never bypasses stale data.
// STRUCTURE
//  defines.vh gains: `EX_TO_MEM_WD 179, `MEM_TO_ID_WD 104, mem_op codes `MEM_LB..`MEM_LW.
//   Field LSB constants go there too.
//  Sub-module load_ext (mem_op, addr_lo, rdata -> 32-bit extended data), purely combinational.
//  FSM and data_buf stay in mem_stage.
// TESTING
//  LB, addr_lo=2'b11, rdata=32'h80FF_1234, rvalid same cycle -> rf_wdata=32'hFFFF_FF80, no stall.
//  LHU, addr_lo=2'b10, rdata=32'h9ABC_0000, rvalid 3 cycles late -> stallreq high exactly 3
//   cycles; then rf_wdata=32'h0000_9ABC.
//  LW, rvalid pulse while stall=6'b011111 (WB-held) -> state HOLD. After release, WB gets
//   captured word and rvalid is not needed again.
//  stall=6'b001111 -> mem_to_wb_bus=0 next cycle. stall=6'b011111 -> bus held unchanged.
//  excepttype=5'h04 on LW with rf_we=1 -> rf_we=0 on both buses, stallreq=0, pc passed.
//  flush asserted in WAIT -> stallreq 0 next cycle, bubble out. Late rvalid causes no write.
//  rst asserted in HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared bus layouts and load-op encodings for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 179;
    localparam int unsigned MEM_TO_WB_WD = 174;
    localparam int unsigned MEM_TO_ID_WD = 104;

    typedef enum logic [2:0] {
        MEM_NONE = 3'b000,
        MEM_LB   = 3'b001,
        MEM_LBU  = 3'b010,
        MEM_LH   = 3'b011,
        MEM_LHU  = 3'b100,
        MEM_LW   = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_WAIT = 2'b01,
        LD_HOLD = 2'b10
    } ld_state_e;

    // Field order is MSB first; it fixes the bit positions on each bus.
    typedef struct packed {
        logic [31:0] badvaddr;
        logic        delayslot;
        logic [4:0]  excepttype;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic [2:0]  mem_op;
        logic [1:0]  addr_lo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic        delayslot;
        logic [4:0]  excepttype;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Selects the byte/half/word addressed by a load and sign- or zero-extends it.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (mem_op)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'd0, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, waits for load data, and feeds WB and ID bypass.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit LOAD_WAIT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    stallreq_for_mem
);
    ex_to_mem_t  in_r;
    ld_state_e   state;
    mem_to_wb_t  wb;
    mem_to_id_t  id;
    logic [31:0] data_buf;
    logic [31:0] ld_src;
    logic [31:0] ld_data;
    logic        rvalid;
    logic        wr_ok;
    logic        load_pending;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};
    assign rvalid = LOAD_WAIT_EN ? data_sram_rvalid : 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush)
            in_r <= '0;
        else if (stall[3] && !stall[4])
            in_r <= '0;
        else if (!stall[3])
            in_r <= ex_to_mem_t'(ex_to_mem_bus);
    end

    assign wr_ok        = (in_r.excepttype == '0);
    assign load_pending = is_load_op(in_r.mem_op) && wr_ok;
    // Drops in the rvalid cycle so the pipeline releases with the data, not one cycle after.
    assign stallreq_for_mem = load_pending && !rvalid && (state != LD_HOLD);
    assign ld_src = (state == LD_HOLD) ? data_buf : data_sram_rdata;

    load_ext u_load_ext (
        .mem_op  (in_r.mem_op),
        .addr_lo (in_r.addr_lo),
        .rdata   (ld_src),
        .data    (ld_data)
    );

    always_comb begin
        wb            = '0;
        wb.badvaddr   = in_r.badvaddr;
        wb.delayslot  = in_r.delayslot;
        wb.excepttype = in_r.excepttype;
        wb.lo_we      = in_r.lo_we && wr_ok;
        wb.lo_wdata   = in_r.lo_wdata;
        wb.hi_we      = in_r.hi_we && wr_ok;
        wb.hi_wdata   = in_r.hi_wdata;
        wb.pc         = in_r.pc;
        wb.rf_we      = in_r.rf_we && wr_ok;
        wb.rf_waddr   = in_r.rf_waddr;
        wb.rf_wdata   = is_load_op(in_r.mem_op) ? ld_data : in_r.ex_result;

        id          = '0;
        id.lo_we    = wb.lo_we;
        id.lo_wdata = wb.lo_wdata;
        id.hi_we    = wb.hi_we;
        id.hi_wdata = wb.hi_wdata;
        id.rf_we    = wb.rf_we && !stallreq_for_mem;
        id.rf_waddr = wb.rf_waddr;
        id.rf_wdata = wb.rf_wdata;
    end

    assign mem_to_wb_bus = wb;
    assign mem_to_id_bus = id;

    // A one-shot rvalid that lands while MEM is held is parked in data_buf until release.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= LD_IDLE;
            data_buf <= '0;
        end else begin
            case (state)
                LD_IDLE, LD_WAIT: begin
                    if (!load_pending)
                        state <= LD_IDLE;
                    else if (!rvalid)
                        state <= LD_WAIT;
                    else if (stall[3]) begin
                        data_buf <= data_sram_rdata;
                        state    <= LD_HOLD;
                    end else
                        state <= LD_IDLE;
                end
                LD_HOLD: if (!stall[3]) state <= LD_IDLE;
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [178:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_rvalid;
    logic [173:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;
    logic         stallreq_for_mem;

    int tests = 0;
    int fails = 0;

    // Reference model: the instruction held in MEM, plus a word remembered if its
    // load data arrived while MEM was held.
    logic [178:0] m_bus  = '0;
    bit           m_got  = 1'b0;
    logic [31:0]  m_word = '0;
    logic [173:0] exp_wb;
    logic [103:0] exp_id;
    logic         exp_sr;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus),
        .stallreq_for_mem (stallreq_for_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [178:0] mk_bus(input logic [2:0] op, input logic [1:0] alo,
                                            input logic [4:0] exc, input logic [2:0] we,
                                            input logic [4:0] waddr, input logic [31:0] res,
                                            input logic [31:0] pc);
        // we = {rf_we, hi_we, lo_we}
        return {pc + 32'd4, pc[2], exc, we[0], ~res, we[1], res ^ 32'h5555_5555,
                op, alo, pc, we[2], waddr, res};
    endfunction

    function automatic void model_out(input logic [178:0] b, input bit got, input logic [31:0] word,
                                      input logic [31:0] rd, input logic rv,
                                      output logic [173:0] wb, output logic [103:0] id,
                                      output logic sr);
        logic [2:0]  op;
        logic [1:0]  alo;
        logic        ok, ld, rf_w, hi_w, lo_w;
        logic [31:0] src, bv, hv, wd;
        op  = b[74:72];
        alo = b[71:70];
        ok  = (b[145:141] == 5'd0);
        ld  = (op >= 3'd1) && (op <= 3'd5);
        src = got ? word : rd;
        bv  = (src >> (8 * alo)) & 32'h0000_00FF;
        hv  = (src >> (16 * alo[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    wd = bv[7] ? (bv | 32'hFFFF_FF00) : bv;
            3'd2:    wd = bv;
            3'd3:    wd = hv[15] ? (hv | 32'hFFFF_0000) : hv;
            3'd4:    wd = hv;
            3'd5:    wd = src;
            default: wd = b[31:0];
        endcase
        sr   = ld && ok && !got && !rv;
        rf_w = b[37] && ok;
        hi_w = b[107] && ok;
        lo_w = b[140] && ok;
        wb = {b[178:147], b[146], b[145:141], lo_w, b[139:108], hi_w, b[106:75],
              b[69:38], rf_w, b[36:32], wd};
        id = {lo_w, b[139:108], hi_w, b[106:75], rf_w && !sr, b[36:32], wd};
    endfunction

    // Drive one cycle's inputs; the stall controller holds MEM and WB whenever a load is outstanding.
    task automatic apply(input logic r, input logic f, input logic [5:0] es,
                         input logic [178:0] b, input logic [31:0] rd, input logic rv);
        rst = r;
        flush = f;
        ex_to_mem_bus = b;
        data_sram_rdata = rd;
        data_sram_rvalid = rv;
        model_out(m_bus, m_got, m_word, rd, rv, exp_wb, exp_id, exp_sr);
        stall = es | (exp_sr ? 6'b011111 : 6'b000000);
        #1;
    endtask

    task automatic tick();
        logic [2:0] op;
        @(posedge clk);
        op = m_bus[74:72];
        if (rst || flush) begin
            m_bus = '0;
            m_got = 1'b0;
        end else begin
            if ((op >= 3'd1) && (op <= 3'd5) && (m_bus[145:141] == 5'd0) && !m_got
                && data_sram_rvalid && stall[3]) begin
                m_got  = 1'b1;
                m_word = data_sram_rdata;
            end
            if (stall[3] && !stall[4]) begin
                m_bus = '0;
                m_got = 1'b0;
            end else if (!stall[3]) begin
                m_bus = ex_to_mem_bus;
                m_got = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 6'd0, mk_bus(3'd5, 2'd1, 5'd0, 3'b111, 5'd3, 32'hABCD_0123, 32'h1000),
              32'hFFFF_FFFF, 1'b1);
        tick();
        apply(1'b1, 1'b0, 6'd0, mk_bus(3'd5, 2'd1, 5'd0, 3'b111, 5'd3, 32'hABCD_0123, 32'h1000),
              32'hFFFF_FFFF, 1'b0);
        tests++;
        if (mem_to_wb_bus !== 174'd0) begin
            fails++;
            $display("FAIL reset_wb: got %h want 0", mem_to_wb_bus);
        end
        tests++;
        if (mem_to_id_bus !== 104'd0) begin
            fails++;
            $display("FAIL reset_id: got %h want 0", mem_to_id_bus);
        end
        tests++;
        if (stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL reset_stallreq: got %b want 0", stallreq_for_mem);
        end
        tick();
    endtask

    task automatic test_lb_same_cycle();
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd1, 2'b11, 5'd0, 3'b100, 5'd5, 32'h0000_1003, 32'h2000),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, 32'h80FF_1234, 1'b1);
        tests++;
        if (mem_to_wb_bus[31:0] !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_wdata: got %h want ffffff80", mem_to_wb_bus[31:0]);
        end
        tests++;
        if (stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL lb_nostall: got %b want 0", stallreq_for_mem);
        end
        tests++;
        if (mem_to_id_bus[37] !== 1'b1 || mem_to_id_bus[31:0] !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_bypass: we=%b data=%h want 1 ffffff80",
                     mem_to_id_bus[37], mem_to_id_bus[31:0]);
        end
        tick();
    endtask

    task automatic test_lhu_late();
        int stalled = 0;
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd4, 2'b10, 5'd0, 3'b100, 5'd6, 32'h0000_2002, 32'h3000),
              '0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 6'd0, mk_bus(3'd0, 2'd0, 5'd0, 3'b100, 5'd7, 32'h77, 32'h3004),
                  32'h1111_1111, 1'b0);
            if (stallreq_for_mem === 1'b1) stalled++;
            if (i == 0) begin
                tests++;
                if (mem_to_id_bus[37] !== 1'b0) begin
                    fails++;
                    $display("FAIL lhu_bypass_blocked: got %b want 0", mem_to_id_bus[37]);
                end
            end
            tick();
        end
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd0, 2'd0, 5'd0, 3'b100, 5'd7, 32'h77, 32'h3004),
              32'h9ABC_0000, 1'b1);
        if (stallreq_for_mem === 1'b1) stalled++;
        tests++;
        if (stalled != 3) begin
            fails++;
            $display("FAIL lhu_stall_cycles: got %0d want 3", stalled);
        end
        tests++;
        if (mem_to_wb_bus[31:0] !== 32'h0000_9ABC || mem_to_wb_bus[37] !== 1'b1) begin
            fails++;
            $display("FAIL lhu_wdata: got %h we=%b want 00009abc we=1",
                     mem_to_wb_bus[31:0], mem_to_wb_bus[37]);
        end
        tick();
    endtask

    task automatic test_hold();
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd5, 2'b00, 5'd0, 3'b100, 5'd8, 32'h0000_4000, 32'h4000),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'b011111, '0, 32'hCAFE_F00D, 1'b1);
        tick();
        apply(1'b0, 1'b0, 6'b011111, '0, 32'h1111_2222, 1'b0);
        tests++;
        if (mem_to_wb_bus[31:0] !== 32'hCAFE_F00D || stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL hold_held: data=%h sr=%b want cafef00d 0",
                     mem_to_wb_bus[31:0], stallreq_for_mem);
        end
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, 32'h3333_4444, 1'b0);
        tests++;
        if (mem_to_wb_bus[31:0] !== 32'hCAFE_F00D || mem_to_wb_bus[37] !== 1'b1
            || stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: data=%h we=%b sr=%b want cafef00d 1 0",
                     mem_to_wb_bus[31:0], mem_to_wb_bus[37], stallreq_for_mem);
        end
        tick();
    endtask

    task automatic test_stall_bubble();
        logic [178:0] x;
        x = mk_bus(3'd0, 2'd0, 5'd0, 3'b100, 5'd7, 32'h1234_5678, 32'h5000);
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, x, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'b011111, mk_bus(3'd0, 2'd0, 5'd0, 3'b100, 5'd9, 32'h9, 32'h5004),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'b001111, '0, '0, 1'b0);
        tests++;
        if (mem_to_wb_bus[31:0] !== 32'h1234_5678 || mem_to_wb_bus[36:32] !== 5'd7
            || mem_to_wb_bus[69:38] !== 32'h5000) begin
            fails++;
            $display("FAIL stall_hold: data=%h addr=%0d pc=%h want 12345678 7 5000",
                     mem_to_wb_bus[31:0], mem_to_wb_bus[36:32], mem_to_wb_bus[69:38]);
        end
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, '0, 1'b0);
        tests++;
        if (mem_to_wb_bus !== 174'd0) begin
            fails++;
            $display("FAIL stall_bubble: got %h want 0", mem_to_wb_bus);
        end
        tick();
    endtask

    task automatic test_exception();
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd5, 2'd0, 5'h04, 3'b111, 5'd10, 32'h0000_6001, 32'hBFC0_0100),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, 32'h5A5A_5A5A, 1'b0);
        tests++;
        if (mem_to_wb_bus[37] !== 1'b0 || mem_to_wb_bus[102] !== 1'b0 || mem_to_wb_bus[135] !== 1'b0
            || mem_to_id_bus[37] !== 1'b0 || mem_to_id_bus[70] !== 1'b0 || mem_to_id_bus[103] !== 1'b0) begin
            fails++;
            $display("FAIL exc_we: wb rf/hi/lo=%b%b%b id=%b%b%b want 000 000",
                     mem_to_wb_bus[37], mem_to_wb_bus[102], mem_to_wb_bus[135],
                     mem_to_id_bus[37], mem_to_id_bus[70], mem_to_id_bus[103]);
        end
        tests++;
        if (stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL exc_nostall: got %b want 0", stallreq_for_mem);
        end
        tests++;
        if (mem_to_wb_bus[69:38] !== 32'hBFC0_0100 || mem_to_wb_bus[140:136] !== 5'h04) begin
            fails++;
            $display("FAIL exc_pass: pc=%h exc=%h want bfc00100 04",
                     mem_to_wb_bus[69:38], mem_to_wb_bus[140:136]);
        end
        tick();
    endtask

    task automatic test_flush();
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd5, 2'd0, 5'd0, 3'b100, 5'd11, 32'h7000, 32'h7000),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, '0, 1'b0);
        tick();
        apply(1'b0, 1'b1, 6'd0, '0, '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, 32'hDEAD_BEEF, 1'b1);
        tests++;
        if (stallreq_for_mem !== 1'b0 || mem_to_wb_bus !== 174'd0 || mem_to_id_bus[37] !== 1'b0) begin
            fails++;
            $display("FAIL flush_wait: sr=%b wb=%h id_we=%b want 0 0 0",
                     stallreq_for_mem, mem_to_wb_bus, mem_to_id_bus[37]);
        end
        tick();
        apply(1'b0, 1'b0, 6'd0, '0, '0, 1'b0);
        tests++;
        if (mem_to_wb_bus !== 174'd0 || stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL flush_late_rvalid: wb=%h sr=%b want 0 0", mem_to_wb_bus, stallreq_for_mem);
        end
        tick();
    endtask

    task automatic test_rst_in_hold();
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        apply(1'b0, 1'b0, 6'd0, mk_bus(3'd5, 2'd0, 5'd0, 3'b111, 5'd12, 32'h8000, 32'h8000),
              '0, 1'b0);
        tick();
        apply(1'b0, 1'b0, 6'b011111, '0, 32'h0BAD_F00D, 1'b1);
        tick();
        apply(1'b1, 1'b0, 6'b011111, '0, 32'h0BAD_F00D, 1'b0);
        tick();
        apply(1'b1, 1'b0, 6'd0, '0, 32'h0BAD_F00D, 1'b0);
        tests++;
        if (mem_to_wb_bus !== 174'd0 || mem_to_id_bus !== 104'd0 || stallreq_for_mem !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold: wb=%h id=%h sr=%b want all 0",
                     mem_to_wb_bus, mem_to_id_bus, stallreq_for_mem);
        end
        tick();
    endtask

    task automatic test_random();
        logic [178:0] b;
        logic [5:0]   es;
        int           r;
        apply(1'b1, 1'b0, 6'd0, '0, '0, 1'b0); tick();
        for (int n = 0; n < 400; n++) begin
            b = '0;
            b[178:147] = $urandom;
            b[146]     = 1'($urandom_range(0, 1));
            b[145:141] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            b[140]     = 1'($urandom_range(0, 1));
            b[139:108] = $urandom;
            b[107]     = 1'($urandom_range(0, 1));
            b[106:75]  = $urandom;
            b[74:72]   = 3'($urandom_range(0, 7));
            b[71:70]   = 2'($urandom_range(0, 3));
            b[69:38]   = $urandom;
            b[37]      = 1'($urandom_range(0, 1));
            b[36:32]   = 5'($urandom_range(0, 31));
            b[31:0]    = $urandom;
            r = $urandom_range(0, 9);
            es = (r == 6 || r == 7) ? 6'b011111 : (r == 8) ? 6'b001111 : 6'b000000;
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0), es, b,
                  $urandom, ($urandom_range(0, 2) == 0));
            tests++;
            if (mem_to_wb_bus !== exp_wb) begin
                fails++;
                $display("FAIL rand_wb[%0d]: got %h want %h", n, mem_to_wb_bus, exp_wb);
            end
            tests++;
            if (mem_to_id_bus !== exp_id) begin
                fails++;
                $display("FAIL rand_id[%0d]: got %h want %h", n, mem_to_id_bus, exp_id);
            end
            tests++;
            if (stallreq_for_mem !== exp_sr) begin
                fails++;
                $display("FAIL rand_stallreq[%0d]: got %b want %b", n, stallreq_for_mem, exp_sr);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        stall = '0;
        ex_to_mem_bus = '0;
        data_sram_rdata = '0;
        data_sram_rvalid = 1'b0;
        test_reset();
        test_lb_same_cycle();
        test_lhu_late();
        test_hold();
        test_stall_bubble();
        test_exception();
        test_flush();
        test_rst_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
